cu_sequencer: RTL and testbench
===============================

# cu_sequencer

Microprogrammed control unit for the ARM datapath. A Moore state machine produces the 35-bit `cu_datapath` control word each cycle and advances on `IR_OUT`, `CONDTESTER_OUT`, `MOC`, `LSM_DETECT` and `LSM_END`. It sequences the datapath through fetch, decode, data-processing, single load/store, load/store-multiple and branch flows. It sits beside the datapath: its outputs feed the datapath and the datapath's status outputs feed back into it.

## Interface
- No parameters.
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-low.
- `IR_OUT` in 32: current instruction.
- `CONDTESTER_OUT` in 1: condition of `IR_OUT[31:28]` passed.
- `MOC` in 1: memory operation complete.
- `LSM_DETECT` in 1: LSM manager has a register to transfer.
- `LSM_END` in 1: LSM manager list exhausted.
- `cu_datapath` out 35: control word.
- `state_out` out 5: current state code, debug only.

## Operation
Control word fields:
- [34] RF-load source: 0 = bit 32, 1 = `CONDTESTER_OUT`.
- [33] flag-register load.
- [32] RF load.
- [31] IR load.
- [30] MAR load.
- [29] MDR load.
- [28] mem R/W, 1 = read.
- [27] mem enable.
- [26:25] MA select.
- [24:22] MB select.
- [21:19] MC select.
- [18:17] MD select.
- [16] ME select.
- [15:11] ALU op.
- [10] SLS enable.
- [9:7] data size.
- [6] LSM load.
- [5:3] LSM mode.
- [2:1] MH select.
- [0] MF select.

States (code in brackets) and the actions they drive:
- RST [0]: word all-zero. Go to FETCH0.
- FETCH0 [1]: MAR <- R15. MA=1 (R15), MB=4 (zero), MD=0, op=00100 (ADD), [30]=1.
- FETCH1 [2]: R15 <- R15+4. op=10010 (B+4), MC=1, [32]=1, [34]=0. Start word read: [27]=1, [28]=1, MH=0, MF=0, size=3'b010.
- FETCH2 [3]: hold the read. IR load [31]=1 only in the cycle `MOC`=1, then go to DECODE. Otherwise stay.
- DECODE [4]: word all-zero except the read is de-asserted. Branch:
  - `CONDTESTER_OUT`=0 → FETCH0.
  - `IR_OUT[27:26]`=00 → DP.
  - `IR_OUT[27:26]`=01 → LS_ADDR.
  - `IR_OUT[27:25]`=100 → LSM_INIT.
  - `IR_OUT[27:25]`=101 → BR.
  - Anything else → FETCH0 (treated as a NOP).
- DP [5]: Rd <- Rn op shifter. MA=0, MB=1, MD=1, MC=3, [32]=1. Flag load via [33]=1 gated by `IR_OUT[20]` inside the datapath. Opcodes 1000–1011 (test/compare) force [32]=0. Then FETCH0.
- LS_ADDR [6]: MAR <- Rn ± offset. MD=1, [30]=1. On store also MDR <- Rd via ME=0 path, [29]=1. Then LS_WAIT.
- LS_WAIT [7]: [27]=1, MH=1, MF=1, SLS enable [10]=1. On load, [29]=1 with ME=1 latches data when `MOC`=1. Exit on `MOC` to LS_WB.
- LS_WB [8]: load → Rd <- MDR (MB=2, op MOV, MC=3, [32]=1). Store → no RF write. Then FETCH0.
- LSM_INIT [9]: [6]=1, mode = `IR_OUT[24:23]`. MAR <- start address via MD=2. Then LSM_LOOP.
- LSM_LOOP [10]:
  - `LSM_END`=1 → LSM_WB.
  - `LSM_DETECT`=1 → LSM_WAIT.
  - Otherwise advance the counter, mode 3'b100.
- LSM_WAIT [11]: transfer one word (MA/MC=2 counter). Exit on `MOC` to LSM_NEXT.
- LSM_NEXT [12]: MAR <- MAR+4 (MB=3, op 10010). Then LSM_LOOP.
- LSM_WB [13]: if `IR_OUT[21]` (writeback), Rn updated via MD=3. Then FETCH0.
- BR [14]: R15 <- R15 + shifted offset. `IR_OUT[24]` (link) first → BRL [15]: R14 <- R15, MC=2, [32]=1. Then FETCH0.

Unused codes 16–31 → RST.

## Timing
- Outputs are decoded combinationally from the state register only. No input reaches an output in the same cycle except the FETCH2/LS_WAIT `MOC` gating of [31]/[29].
- While `RESET`=0 at a rising edge: state=RST and `cu_datapath`=35'd0 from the next cycle.
- A reset asserted mid-memory access aborts the access. No completion is awaited.
- Minimum instruction latency:
  - DP: 5 cycles (FETCH0..DECODE, DP), with `MOC` arriving the cycle after FETCH1.
  - Condition-fail: 4 cycles.
- `MOC` held high across a state boundary is consumed once per wait state.
- `MOC` arriving in FETCH1 is ignored; FETCH2 requires `MOC` sampled in FETCH2.
- No timeout: a missing `MOC` stalls indefinitely.
- `LSM_END` takes priority over `LSM_DETECT` when both are asserted.

## Test plan
- Reset: hold `RESET`=0 for 3 cycles → `cu_datapath`=0 and `state_out`=0. Release → FETCH0 word has [30]=1 and [26:25]=01.
- ADD R1,R2,R3 (`IR_OUT`=32'hE0821003), cond pass, `MOC` 1 cycle after FETCH1 → state sequence 1,2,3,4,5,1. DP word has [32]=1 and [15:11]=00100.
- Same instruction with `CONDTESTER_OUT`=0 → 1,2,3,4,1. [32] never asserts after FETCH1.
- LDR R0,[R1] (32'hE5910000), `MOC` delayed 3 cycles → LS_WAIT holds 3 cycles, [29]=1 only in the `MOC` cycle, LS_WB has [32]=1.
- LDM with 2 registers: `LSM_DETECT` pulses twice, then `LSM_END` → LSM_WAIT entered exactly twice, LSM_WB once.
- BL (32'hEB000004) → BR then BRL. BRL has [21:19]=010 and [32]=1. Reset asserted in LSM_WAIT → RST on the next edge.

Source files
------------

// File: rtl/cu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cu_sequencer_if
// Purpose  : Status and control bundle between the control unit and datapath.
// Revision : 1.0
// ============================================================================
interface cu_sequencer_if;
  logic [31:0] IR_OUT;
  logic        CONDTESTER_OUT;
  logic        MOC;
  logic        LSM_DETECT;
  logic        LSM_END;
  logic [34:0] cu_datapath;
  logic [4:0]  state_out;

  modport master (
    input  IR_OUT, CONDTESTER_OUT, MOC, LSM_DETECT, LSM_END,
    output cu_datapath, state_out
  );

  modport slave (
    output IR_OUT, CONDTESTER_OUT, MOC, LSM_DETECT, LSM_END,
    input  cu_datapath, state_out
  );
endinterface
`default_nettype wire

// File: rtl/cu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cu_sequencer
// Purpose  : Moore control unit sequencing fetch/decode/execute for the datapath.
// Revision : 1.0
// ============================================================================
module cu_sequencer (
  input  logic           CLK,
  input  logic           RESET,
  cu_sequencer_if.master bus
);

  typedef enum logic [4:0] {
    ST_RST      = 5'd0,
    ST_FETCH0   = 5'd1,
    ST_FETCH1   = 5'd2,
    ST_FETCH2   = 5'd3,
    ST_DECODE   = 5'd4,
    ST_DP       = 5'd5,
    ST_LS_ADDR  = 5'd6,
    ST_LS_WAIT  = 5'd7,
    ST_LS_WB    = 5'd8,
    ST_LSM_INIT = 5'd9,
    ST_LSM_LOOP = 5'd10,
    ST_LSM_WAIT = 5'd11,
    ST_LSM_NEXT = 5'd12,
    ST_LSM_WB   = 5'd13,
    ST_BR       = 5'd14,
    ST_BRL      = 5'd15
  } state_t;

  localparam logic [4:0] c_alu_sub    = 5'b00010;
  localparam logic [4:0] c_alu_add    = 5'b00100;
  localparam logic [4:0] c_alu_mov    = 5'b01101;
  localparam logic [4:0] c_alu_pass_a = 5'b10000;
  localparam logic [4:0] c_alu_bplus4 = 5'b10010;
  localparam logic [2:0] c_size_word  = 3'b010;
  localparam logic [2:0] c_size_byte  = 3'b000;

  state_t      state_q, state_d;
  logic [34:0] word_q, word_d;
  logic [34:0] moc_bits;
  logic        unused_ir_bits;

  // f = IR[24:20]: {P/opc3, U/opc2, B/opc1, W/opc0, L/S}
  function automatic logic [34:0] decode_word(input state_t st, input logic [4:0] f);
    logic [34:0] w;
    w = '0;
    case (st)
      ST_FETCH0: begin
        w[30]    = 1'b1;
        w[26:25] = 2'd1;
        w[24:22] = 3'd4;
        w[18:17] = 2'd0;
        w[15:11] = c_alu_add;
      end
      ST_FETCH1: begin
        w[32]    = 1'b1;
        w[28]    = 1'b1;
        w[27]    = 1'b1;
        w[26:25] = 2'd1;
        w[21:19] = 3'd1;
        w[15:11] = c_alu_bplus4;
        w[9:7]   = c_size_word;
      end
      ST_FETCH2: begin
        w[28]    = 1'b1;
        w[27]    = 1'b1;
        w[9:7]   = c_size_word;
      end
      ST_DP: begin
        w[33]    = 1'b1;
        w[32]    = (f[4:3] != 2'b10);
        w[24:22] = 3'd1;
        w[21:19] = 3'd3;
        w[18:17] = 2'd1;
        w[15:11] = {1'b0, f[4:1]};
      end
      ST_LS_ADDR: begin
        w[30]    = 1'b1;
        w[29]    = ~f[0];
        w[24:22] = 3'd1;
        w[18:17] = 2'd1;
        w[15:11] = f[3] ? c_alu_add : c_alu_sub;
      end
      ST_LS_WAIT: begin
        w[28]    = f[0];
        w[27]    = 1'b1;
        w[16]    = f[0];
        w[10]    = 1'b1;
        w[9:7]   = f[2] ? c_size_byte : c_size_word;
        w[2:1]   = 2'd1;
        w[0]     = 1'b1;
      end
      ST_LS_WB: begin
        if (f[0]) begin
          w[32]    = 1'b1;
          w[24:22] = 3'd2;
          w[21:19] = 3'd3;
          w[15:11] = c_alu_mov;
        end
      end
      ST_LSM_INIT: begin
        w[30]    = 1'b1;
        w[18:17] = 2'd2;
        w[6]     = 1'b1;
        w[5:3]   = {1'b0, f[4:3]};
      end
      ST_LSM_LOOP: begin
        w[5:3]   = 3'b100;
      end
      ST_LSM_WAIT: begin
        w[32]    = f[0];
        w[28]    = f[0];
        w[27]    = 1'b1;
        w[26:25] = 2'd2;
        w[21:19] = 3'd2;
        w[16]    = f[0];
        w[10]    = 1'b1;
        w[9:7]   = c_size_word;
        w[2:1]   = 2'd1;
        w[0]     = 1'b1;
      end
      ST_LSM_NEXT: begin
        w[30]    = 1'b1;
        w[26:25] = 2'd3;
        w[24:22] = 3'd3;
        w[15:11] = c_alu_bplus4;
      end
      ST_LSM_WB: begin
        if (f[1]) begin
          w[32]    = 1'b1;
          w[18:17] = 2'd3;
        end
      end
      ST_BR: begin
        w[32]    = 1'b1;
        w[26:25] = 2'd1;
        w[24:22] = 3'd1;
        w[21:19] = 3'd1;
        w[15:11] = c_alu_add;
      end
      ST_BRL: begin
        w[32]    = 1'b1;
        w[26:25] = 2'd1;
        w[21:19] = 3'd2;
        w[15:11] = c_alu_pass_a;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:      state_d = ST_FETCH0;
      ST_FETCH0:   state_d = ST_FETCH1;
      ST_FETCH1:   state_d = ST_FETCH2;
      ST_FETCH2:   if (bus.MOC) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!bus.CONDTESTER_OUT)               state_d = ST_FETCH0;
        else if (bus.IR_OUT[27:26] == 2'b00)   state_d = ST_DP;
        else if (bus.IR_OUT[27:26] == 2'b01)   state_d = ST_LS_ADDR;
        else if (bus.IR_OUT[27:25] == 3'b100)  state_d = ST_LSM_INIT;
        else if (bus.IR_OUT[27:25] == 3'b101)  state_d = ST_BR;
        else                                   state_d = ST_FETCH0;
      end
      ST_DP:       state_d = ST_FETCH0;
      ST_LS_ADDR:  state_d = ST_LS_WAIT;
      ST_LS_WAIT:  if (bus.MOC) state_d = ST_LS_WB;
      ST_LS_WB:    state_d = ST_FETCH0;
      ST_LSM_INIT: state_d = ST_LSM_LOOP;
      ST_LSM_LOOP: begin
        // End of list wins over a pending transfer.
        if (bus.LSM_END)         state_d = ST_LSM_WB;
        else if (bus.LSM_DETECT) state_d = ST_LSM_WAIT;
      end
      ST_LSM_WAIT: if (bus.MOC) state_d = ST_LSM_NEXT;
      ST_LSM_NEXT: state_d = ST_LSM_LOOP;
      ST_LSM_WB:   state_d = ST_FETCH0;
      ST_BR:       state_d = bus.IR_OUT[24] ? ST_BRL : ST_FETCH0;
      ST_BRL:      state_d = ST_FETCH0;
      default:     state_d = ST_RST;
    endcase
  end

  // The word is registered alongside the state, so it depends only on the state register.
  always_comb begin
    word_d = decode_word(state_d, bus.IR_OUT[24:20]);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_RST;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  // Only the IR and MDR latch strobes follow MOC within the cycle.
  always_comb begin
    moc_bits     = '0;
    moc_bits[31] = (state_q == ST_FETCH2) & bus.MOC;
    moc_bits[29] = (state_q == ST_LS_WAIT) & bus.IR_OUT[20] & bus.MOC;
  end

  assign bus.cu_datapath = word_q | moc_bits;
  assign bus.state_out   = state_q;
  assign unused_ir_bits  = ^{bus.IR_OUT[31:28], bus.IR_OUT[19:0]};

endmodule
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_sequencer
// Purpose  : Instruction-level model bench for the control unit sequencer.
// Revision : 1.0
// ============================================================================
module tb_cu_sequencer;

  typedef struct {
    bit          rst;
    logic [31:0] ir;
    bit          cond;
    bit          moc;
    bit          det;
    bit          lend;
    int          st;
    bit          mark;
  } step_t;

  logic clk;
  logic rst_n;
  cu_sequencer_if bus();

  cu_sequencer dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  step_t       plan[$];
  step_t       cur;
  bit          cur_valid = 0;
  logic [31:0] cur_ir;
  bit          cur_cond;
  bit          pending_mark = 0;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          prev_state = -1;
  int          lsm_wait_cnt = 0;
  int          lsm_wb_cnt = 0;
  logic [34:0] m, v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Instruction class from the top opcode bits: 0 DP, 1 LS, 2 LSM, 3 branch, 4 other.
  function automatic int iclass(input logic [31:0] ir);
    if (ir[27:26] == 2'b00) return 0;
    if (ir[27:26] == 2'b01) return 1;
    if (ir[27:25] == 3'b100) return 2;
    if (ir[27:25] == 3'b101) return 3;
    return 4;
  endfunction

  // Control-word fields the datapath relies on in each state: mask and required value.
  function automatic void model_word(input step_t s, output logic [34:0] mk, output logic [34:0] vl);
    bit         load;
    logic [3:0] opc;
    load = s.ir[20];
    opc  = s.ir[24:21];
    mk = '0;
    vl = '0;
    case (s.st)
      0, 4: mk = '1;
      1: begin
        mk[30] = 1; vl[30] = 1;
        mk[26:25] = '1; vl[26:25] = 2'b01;
        mk[24:22] = '1; vl[24:22] = 3'd4;
        mk[18:17] = '1;
        mk[15:11] = '1; vl[15:11] = 5'b00100;
      end
      2: begin
        mk[15:11] = '1; vl[15:11] = 5'b10010;
        mk[21:19] = '1; vl[21:19] = 3'd1;
        mk[32] = 1; vl[32] = 1;
        mk[34] = 1;
        mk[28:27] = '1; vl[28:27] = 2'b11;
        mk[2:0] = '1;
        mk[9:7] = '1; vl[9:7] = 3'b010;
      end
      3: begin
        mk[28:27] = '1; vl[28:27] = 2'b11;
        mk[31] = 1; vl[31] = s.moc;
      end
      5: begin
        mk[26:25] = '1;
        mk[24:22] = '1; vl[24:22] = 3'd1;
        mk[18:17] = '1; vl[18:17] = 2'd1;
        mk[21:19] = '1; vl[21:19] = 3'd3;
        mk[33] = 1; vl[33] = 1;
        mk[32] = 1; vl[32] = !(opc >= 4'd8 && opc <= 4'd11);
        mk[31] = 1;
      end
      6: begin
        mk[18:17] = '1; vl[18:17] = 2'd1;
        mk[30] = 1; vl[30] = 1;
        mk[29] = 1; vl[29] = !load;
        if (!load) mk[16] = 1;
      end
      7: begin
        mk[27] = 1; vl[27] = 1;
        mk[2:0] = '1; vl[2:0] = 3'b011;
        mk[10] = 1; vl[10] = 1;
        mk[29] = 1; vl[29] = load & s.moc;
        if (load) begin mk[16] = 1; vl[16] = 1; end
      end
      8: begin
        mk[32] = 1; vl[32] = load;
        if (load) begin
          mk[24:22] = '1; vl[24:22] = 3'd2;
          mk[15:11] = '1; vl[15:11] = 5'b01101;
          mk[21:19] = '1; vl[21:19] = 3'd3;
        end
      end
      9: begin
        mk[6] = 1; vl[6] = 1;
        mk[5:3] = '1; vl[5:3] = {1'b0, s.ir[24:23]};
        mk[18:17] = '1; vl[18:17] = 2'd2;
      end
      10: begin mk[5:3] = '1; vl[5:3] = 3'b100; end
      11: begin
        mk[26:25] = '1; vl[26:25] = 2'd2;
        mk[21:19] = '1; vl[21:19] = 3'd2;
      end
      12: begin
        mk[24:22] = '1; vl[24:22] = 3'd3;
        mk[15:11] = '1; vl[15:11] = 5'b10010;
        mk[30] = 1; vl[30] = 1;
      end
      13: if (s.ir[21]) begin mk[18:17] = '1; vl[18:17] = 2'd3; end
      14: begin mk[32] = 1; vl[32] = 1; end
      15: begin
        mk[21:19] = '1; vl[21:19] = 3'd2;
        mk[32] = 1; vl[32] = 1;
      end
      default: mk = '0;
    endcase
  endfunction

  task automatic push(input int st, input bit moc, input bit det, input bit lend, input bit rst);
    step_t s;
    s.rst = rst; s.ir = cur_ir; s.cond = cur_cond;
    s.moc = moc; s.det = det; s.lend = lend; s.st = st;
    s.mark = pending_mark;
    pending_mark = 0;
    plan.push_back(s);
  endtask

  task automatic fetch(input logic [31:0] ir, input bit cond, input int fw, input bit f1moc);
    cur_ir = ir;
    cur_cond = cond;
    push(1, 0, 0, 0, 1);
    push(2, f1moc, 0, 0, 1);
    repeat (fw) push(3, 0, 0, 0, 1);
    push(3, 1, 0, 0, 1);
    push(4, 0, 0, 0, 1);
  endtask

  // One instruction: fetch with fw empty FETCH2 cycles, lsw cycles of memory wait, nregs LSM transfers.
  task automatic run_instr(input logic [31:0] ir, input bit cond, input int fw, input bit f1moc,
                           input int lsw, input int nregs, input bit mark_after);
    fetch(ir, cond, fw, f1moc);
    if (cond) begin
      case (iclass(ir))
        0: push(5, 0, 0, 0, 1);
        1: begin
          push(6, 0, 0, 0, 1);
          repeat (lsw - 1) push(7, 0, 0, 0, 1);
          push(7, 1, 0, 0, 1);
          push(8, 0, 0, 0, 1);
        end
        2: begin
          push(9, 0, 0, 0, 1);
          push(10, 0, 0, 0, 1);
          for (int r = 0; r < nregs; r++) begin
            push(10, 0, 1, 0, 1);
            repeat (r) push(11, 0, 0, 0, 1);
            push(11, 1, 0, 0, 1);
            push(12, 0, 0, 0, 1);
          end
          push(10, 0, 1, 1, 1);
          push(13, 0, 0, 0, 1);
        end
        3: begin
          push(14, 0, 0, 0, 1);
          if (ir[24]) push(15, 0, 0, 0, 1);
        end
        default: ;
      endcase
    end
    pending_mark = mark_after;
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      model_word(cur, m, v);
      chk("state", 64'(bus.state_out), 64'(cur.st));
      chk("word", 64'(bus.cu_datapath & m), 64'(v));
      if (cur.st == 5 && cur.ir == 32'hE0821003)
        chk("add_alu_op", 64'(bus.cu_datapath[15:11]), 64'h04);
      if (cur.st == 15)
        chk("brl_mc_sel", 64'(bus.cu_datapath[21:19]), 64'h2);
      if (cur.st == 1 && cur.ir == 32'hE0821003)
        chk("fetch0_mar_r15", 64'({bus.cu_datapath[30], bus.cu_datapath[26:25]}), 64'h5);
      if (int'(bus.state_out) == 11 && prev_state != 11) lsm_wait_cnt++;
      if (int'(bus.state_out) == 13) lsm_wb_cnt++;
      prev_state = int'(bus.state_out);
      if (cur.mark) begin
        chk("lsm_wait_entries", 64'(lsm_wait_cnt), 64'd2);
        chk("lsm_wb_entries", 64'(lsm_wb_cnt), 64'd1);
        lsm_wait_cnt = 0;
        lsm_wb_cnt = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.IR_OUT = '0;
    bus.CONDTESTER_OUT = 1'b0;
    bus.MOC = 1'b0;
    bus.LSM_DETECT = 1'b0;
    bus.LSM_END = 1'b0;
    cur_ir = '0;
    cur_cond = 1'b0;

    repeat (3) push(0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    run_instr(32'hE0821003, 1, 0, 0, 0, 0, 0);  // ADD
    run_instr(32'hE0821003, 0, 0, 0, 0, 0, 0);  // ADD, condition fails
    run_instr(32'hE0821003, 1, 1, 1, 0, 0, 0);  // ADD, MOC early in FETCH1
    run_instr(32'hE1520003, 1, 0, 0, 0, 0, 0);  // CMP
    run_instr(32'hE5910000, 1, 0, 0, 3, 0, 0);  // LDR
    run_instr(32'hE5810000, 1, 0, 0, 1, 0, 0);  // STR
    run_instr(32'hE8B10006, 1, 0, 0, 0, 2, 1);  // LDM, 2 registers, writeback
    run_instr(32'hEA000004, 1, 0, 0, 0, 0, 0);  // B
    run_instr(32'hEB000004, 1, 0, 0, 0, 0, 0);  // BL
    run_instr(32'hEC000000, 1, 0, 0, 0, 0, 0);  // coprocessor class, NOP
    run_instr(32'hEF000000, 1, 0, 0, 0, 0, 0);  // SWI class, NOP
    // LDM aborted by reset while waiting on memory
    fetch(32'hE8B10006, 1, 0, 0);
    push(9, 0, 0, 0, 1);
    push(10, 0, 1, 0, 1);
    push(11, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    run_instr(32'hE0821003, 1, 2, 0, 0, 0, 0);
    push(1, 0, 0, 0, 1);

    foreach (plan[i]) begin
      @(posedge clk);
      #2;
      rst_n = plan[i].rst;
      bus.IR_OUT = plan[i].ir;
      bus.CONDTESTER_OUT = plan[i].cond;
      bus.MOC = plan[i].moc;
      bus.LSM_DETECT = plan[i].det;
      bus.LSM_END = plan[i].lend;
      cur = plan[i];
      cur_valid = 1;
    end
    @(negedge clk);
    #1;
    cur_valid = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
